// File: rtl/code_loader.sv
// rtl/code_loader.sv - byte-stream code image loader with checksum verification
module code_loader #(
  parameter int BIT_WIDTH     = 32,
  parameter int INST_COUNT    = 256,
  parameter int INST_COUNT_L2 = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [INST_COUNT_L2:0]   word_count,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [INST_COUNT_L2-1:0] mem_waddr,
  output logic [BIT_WIDTH-1:0]     mem_wdata,
  input  logic                     mem_wready,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int BYTES = BIT_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [INST_COUNT_L2:0] MAX_WC   = (INST_COUNT_L2 + 1)'(INST_COUNT);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BYTES - 1);

  logic [2:0]               state_q, state_d;
  logic [INST_COUNT_L2-1:0] addr_q, addr_d;
  logic [INST_COUNT_L2-1:0] last_q, last_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BIT_WIDTH-1:0]     word_q, word_d;
  logic [7:0]               csum_q, csum_d;
  logic                     error_q, error_d;
  logic                     xfer;
  logic                     wc_ok;

  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign wc_ok      = (word_count != '0) && (word_count <= MAX_WC);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    idx_d   = idx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (wc_ok) begin
            state_d = S_RECV;
            addr_d  = '0;
            idx_d   = '0;
            csum_d  = '0;
            error_d = 1'b0;
            // word_count == INST_COUNT truncates to 0, so the last address wraps to INST_COUNT-1
            last_d  = word_count[INST_COUNT_L2-1:0] - 1'b1;
          end else begin
            state_d = S_DONE;
            error_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_data;
          csum_d = csum_q ^ byte_data;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_wready) begin
          addr_d  = addr_q + 1'b1;
          idx_d   = '0;
          state_d = (addr_q == last_q) ? S_CHECK : S_RECV;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          error_d = (byte_data != csum_q);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      error_q <= error_d;
    end
  end

  assign mem_we    = (state_q == S_WRITE);
  assign mem_waddr = addr_q;
  assign mem_wdata = word_q;
  assign busy      = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_code_loader.sv
// tb/tb_code_loader.sv - self-checking bench for code_loader
module tb_code_loader;

  localparam int N  = 256;
  localparam int L2 = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [L2:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [L2-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          mem_wready;
  logic          busy;
  logic          done;
  logic          error;

  code_loader #(.BIT_WIDTH(32), .INST_COUNT(N), .INST_COUNT_L2(L2)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory-side responder: stall each write by stall_mode cycles (random 0..3 when negative)
  int stall_mode = 0;
  int cur_stall  = 0;
  int we_cnt     = 0;
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      if (we_cnt == 0) cur_stall = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
      mem_wready = (we_cnt >= cur_stall);
      we_cnt++;
    end else begin
      mem_wready = 1'b0;
      we_cnt = 0;
    end
  end

  // observer: captures completed writes and checks write-phase properties
  logic [L2-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            done_cnt = 0;
  int            busy_cnt = 0;
  int            we_total = 0;
  int            run = 0;
  int            last_run = 0;
  bit            prev_wait = 1'b0;
  logic [L2-1:0] prev_addr;
  logic [31:0]   prev_data;
  always @(negedge clk) begin
    if (reset) begin
      prev_wait = 1'b0;
      run = 0;
    end else begin
      if (prev_wait) begin
        chk("we_held", 64'(mem_we), 64'd1);
        chk("waddr_stable", 64'(mem_waddr), 64'(prev_addr));
        chk("wdata_stable", 64'(mem_wdata), 64'(prev_data));
      end
      if (mem_we) begin
        chk("ready_low_in_write", 64'(byte_ready), 64'd0);
        run++;
        we_total++;
      end
      if (mem_we && mem_wready) begin
        wr_addr_q.push_back(mem_waddr);
        wr_data_q.push_back(mem_wdata);
        last_run = run;
        run = 0;
      end
      prev_wait = mem_we && !mem_wready;
      prev_addr = mem_waddr;
      prev_data = mem_wdata;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  logic [7:0] src_q[$];

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int n;
    bit got;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    if (pulse) begin
      start = 1'b1;
      word_count = 9'($urandom_range(0, 300));
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (byte_ready) got = 1'b1;
    end
    if (!got) chk("byte_accept_timeout", 64'd0, 64'd1);
    tick();
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_load(input int wc, input bit bad, input int stall, input bit gaps,
                         input bit pulse, input bit keep_src, input int exp_writes, input bit exp_err);
    bit         valid;
    logic [7:0] csum;
    logic [31:0] exp_w[$];
    int         done0, busy0, we0, n;
    bit         seen;
    valid = (wc >= 1) && (wc <= N);
    if (!keep_src) begin
      src_q.delete();
      if (valid) for (int k = 0; k < wc * 4; k++) src_q.push_back(8'($urandom));
    end
    csum = 8'h00;
    foreach (src_q[k]) csum ^= src_q[k];
    for (int i = 0; i < src_q.size() / 4; i++)
      exp_w.push_back({src_q[4*i+3], src_q[4*i+2], src_q[4*i+1], src_q[4*i]});
    wr_addr_q.delete();
    wr_data_q.delete();
    stall_mode = stall;
    tick();
    done0 = done_cnt;
    busy0 = busy_cnt;
    we0   = we_total;
    start = 1'b1;
    word_count = 9'(wc);
    tick();
    start = 1'b0;
    if (valid) begin
      foreach (src_q[k])
        send_byte(src_q[k], gaps ? int'($urandom_range(0, 3)) : 0, pulse && k > 0 && $urandom_range(0, 2) == 0);
      send_byte(bad ? csum ^ 8'($urandom_range(1, 255)) : csum, gaps ? int'($urandom_range(0, 3)) : 0, 1'b0);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("error_at_done", 64'(error), 64'(exp_err));
    chk("busy_at_done", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("error_held", 64'(error), 64'(exp_err));
    chk("done_pulses", 64'(done_cnt - done0), 64'd1);
    chk("write_count", 64'(wr_addr_q.size()), 64'(exp_writes));
    for (int i = 0; i < wr_addr_q.size() && i < exp_w.size(); i++) begin
      chk("write_addr", 64'(wr_addr_q[i]), 64'(i));
      chk("write_data", 64'(wr_data_q[i]), 64'(exp_w[i]));
    end
    if (!valid) begin
      chk("busy_never", 64'(busy_cnt - busy0), 64'd0);
      chk("we_never", 64'(we_total - we0), 64'd0);
    end
  endtask

  typedef struct {
    int wc;
    bit bad;
    int stall;
    bit gaps;
    bit pulse;
    int exp_writes;
    bit exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{wc: 2,   bad: 1, stall: 0,  gaps: 0, pulse: 0, exp_writes: 2,   exp_err: 1};
    vecs[1] = '{wc: 0,   bad: 0, stall: 0,  gaps: 0, pulse: 0, exp_writes: 0,   exp_err: 1};
    vecs[2] = '{wc: 257, bad: 0, stall: 0,  gaps: 0, pulse: 0, exp_writes: 0,   exp_err: 1};
    vecs[3] = '{wc: 3,   bad: 0, stall: -1, gaps: 1, pulse: 1, exp_writes: 3,   exp_err: 0};
    vecs[4] = '{wc: 8,   bad: 1, stall: -1, gaps: 1, pulse: 1, exp_writes: 8,   exp_err: 1};
    vecs[5] = '{wc: 256, bad: 0, stall: 0,  gaps: 0, pulse: 0, exp_writes: 256, exp_err: 0};
    vecs[6] = '{wc: 1,   bad: 0, stall: 2,  gaps: 1, pulse: 0, exp_writes: 1,   exp_err: 0};
    vecs[7] = '{wc: 16,  bad: 0, stall: -1, gaps: 1, pulse: 1, exp_writes: 16,  exp_err: 0};

    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    mem_wready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);

    // known single-word image with matching checksum 0x50
    src_q = '{8'h13, 8'h00, 8'hA0, 8'hE3};
    do_load(1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    if (wr_data_q.size() > 0) chk("fixed_word", 64'(wr_data_q[0]), 64'hE3A00013);

    // three-cycle write stall: mem_we must be held four cycles
    do_load(1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    chk("stall_we_cycles", 64'(last_run), 64'd4);

    for (int t = 0; t < 8; t++)
      do_load(vecs[t].wc, vecs[t].bad, vecs[t].stall, vecs[t].gaps, vecs[t].pulse, 1'b0,
              vecs[t].exp_writes, vecs[t].exp_err);

    // reset after two bytes of word 3 aborts the load
    begin
      int done0;
      src_q.delete();
      for (int k = 0; k < 20; k++) src_q.push_back(8'($urandom));
      wr_addr_q.delete();
      wr_data_q.delete();
      stall_mode = 0;
      tick();
      start = 1'b1;
      word_count = 9'd5;
      tick();
      start = 1'b0;
      for (int k = 0; k < 14; k++) send_byte(src_q[k], 0, 1'b0);
      done0 = done_cnt;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_byte_ready", 64'(byte_ready), 64'd0);
      chk("abort_mem_we", 64'(mem_we), 64'd0);
      chk("abort_waddr", 64'(mem_waddr), 64'd0);
      chk("abort_wdata", 64'(mem_wdata), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_error", 64'(error), 64'd0);
      repeat (6) tick();
      chk("abort_writes", 64'(wr_addr_q.size()), 64'd3);
      chk("abort_no_done", 64'(done_cnt - done0), 64'd0);
    end
    do_load(2, 1'b0, -1, 1'b1, 1'b0, 1'b0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_loader.md
CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 Parameter: BIT_WIDTH, 32, instruction word width in bits.
REQ-002 Parameter: INST_COUNT, 256, number of words in code memory.
REQ-003 Parameter: INST_COUNT_L2, 8, log2(INST_COUNT), the code memory word-address width.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset: one clock, synchronous active-high reset.
REQ-006 Port: start  input  1  load request; sampled only in IDLE.
REQ-007 Port: word_count  input  INST_COUNT_L2+1  words to load; sampled with start.
REQ-008 Port: byte_valid  input  1  byte_data holds a valid byte.
REQ-009 Port: byte_data  input  8  incoming image byte.
REQ-010 Port: byte_ready  output  1  loader can accept a byte this cycle.
REQ-011 Port: mem_we  output  1  code memory write request.
REQ-012 Port: mem_waddr  output  INST_COUNT_L2  word address (pc >> 2) being written.
REQ-013 Port: mem_wdata  output  BIT_WIDTH  assembled instruction word.
REQ-014 Port: mem_wready  input  1  code memory accepts the write this cycle.
REQ-015 Port: busy  output  1  load in progress; the CPU front end is held disabled while high.
REQ-016 Port: done  output  1  one-cycle pulse at the end of every load attempt.
REQ-017 Port: error  output  1  status of the last attempt; valid from done until the next accepted start.

Function
REQ-020 States: IDLE, RECV, WRITE, CHECK, DONE; busy SHALL be 1 exactly in RECV, WRITE and CHECK.
REQ-021 IDLE with start=1 and 1 <= word_count <= INST_COUNT: go to RECV; clear address, byte index and checksum to 0; clear error.
REQ-022 IDLE with start=1 and word_count=0 or word_count > INST_COUNT: set error=1, go to DONE, and issue no memory writes.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 A byte transfer occurs only in a cycle where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in RECV and CHECK.
REQ-025 RECV: bytes are assembled little-endian; the first byte goes to bits [7:0] and the fourth to bits [31:24]; every accepted data byte is XORed into the 8-bit checksum.
REQ-026 On acceptance of the fourth byte, go to WRITE; mem_we SHALL be high on the next cycle (1-cycle latency).
REQ-027 WRITE: hold mem_we=1 and keep mem_waddr and mem_wdata stable until mem_wready=1 is sampled; the write completes in that cycle.
REQ-028 When the write completes, increment the address and reset the byte index; go to CHECK if the written address was word_count-1, otherwise go back to RECV.
REQ-029 mem_we SHALL be 0 outside WRITE.
REQ-030 CHECK: accept exactly one byte; set error=1 if it differs from the running checksum, else error=0; go to DONE.
REQ-031 DONE: done=1 for exactly one cycle; go to IDLE the next cycle.
REQ-032 Address arithmetic SHALL wrap modulo INST_COUNT; wrap is unreachable when word_count <= INST_COUNT.
REQ-033 If byte_valid is asserted in IDLE, WRITE or DONE, the loader SHALL not consume the byte.

Reset
REQ-040 When reset=1 at a clock edge, the loader SHALL enter IDLE with byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0 and error=0.
REQ-041 Reset in any state, including mid-word and mid-WRITE, SHALL abort the load: the partial word is discarded, no further writes are issued, and done is not pulsed.
REQ-042 reset SHALL take priority over start and over all handshakes in the same cycle.

Verification
REQ-050 Start with word_count=1, bytes 0x13,0x00,0xA0,0xE3 then checksum 0x50 -> one write at address 0 with data 0xE3A00013; done pulse; error=0.
REQ-051 Start with word_count=2, 8 data bytes and a wrong checksum -> writes at addresses 0 and 1; done pulse; error=1.
REQ-052 Hold mem_wready=0 for 3 cycles in WRITE -> mem_we, mem_waddr and mem_wdata are stable for 4 cycles; byte_ready=0 throughout; exactly one write completes.
REQ-053 Start with word_count=0, and separately with word_count=INST_COUNT+1 -> no mem_we; done one cycle later; error=1; busy never high.
REQ-054 Assert reset after 2 bytes of word 3 -> IDLE next cycle, all outputs 0, no write to address 3, no done pulse; a fresh start then loads correctly from address 0.
REQ-055 Random gaps on byte_valid and start pulsed mid-load -> written image matches the source bytes and the extra start has no effect.
